// File: rtl/serial_adder_pkg.sv
// serial_adder_pkg: shared types and constants
// for the bit-serial adder.
package serial_adder_pkg;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } sa_state_t;

  localparam int SA_WIDTH_DEFAULT = 8;

endpackage

// File: rtl/full_adder.sv
// full_adder: single-bit adder cell
// shared by the serial datapath.
module full_adder (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic sum,
  output logic cout
);

  assign sum  = a ^ b ^ cin;
  assign cout = (a & b) | (cin & (a ^ b));

endmodule

// File: rtl/serial_adder.sv
// serial_adder: LSB-first bit-serial adder
// built around one full_adder cell.
module serial_adder
  import serial_adder_pkg::*;
#(
  parameter int WIDTH = SA_WIDTH_DEFAULT
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  sa_state_t        state_q, state_d;
  logic [WIDTH-1:0] sa_q, sa_d;
  logic [WIDTH-1:0] sb_q, sb_d;
  logic [WIDTH-1:0] sr_q, sr_d;
  logic             c_q, c_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic             cout_q, cout_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;

  logic fa_s;
  logic fa_co;

  full_adder u_fa (
    .a    (sa_q[0]),
    .b    (sb_q[0]),
    .cin  (c_q),
    .sum  (fa_s),
    .cout (fa_co)
  );

  // Next-state, datapath shifts and flag decode.
  always_comb begin
    state_d = state_q;
    sa_d    = sa_q;
    sb_d    = sb_q;
    sr_d    = sr_q;
    c_d     = c_q;
    cnt_d   = cnt_q;
    sum_d   = sum_q;
    cout_d  = cout_q;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          sa_d    = a;
          sb_d    = b;
          c_d     = cin;
          cnt_d   = '0;
          sr_d    = '0;
          state_d = RUN;
        end
      end
      RUN: begin
        sa_d = sa_q >> 1;
        sb_d = sb_q >> 1;
        sr_d = {fa_s, sr_q[WIDTH-1:1]};
        c_d  = fa_co;
        if (cnt_q == LAST) begin
          sum_d   = {fa_s, sr_q[WIDTH-1:1]};
          cout_d  = fa_co;
          state_d = DONE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
    busy_d = (state_d == RUN);
    done_d = (state_d == DONE);
  end

  // State and datapath registers; reset discards any operation.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      sa_q    <= '0;
      sb_q    <= '0;
      sr_q    <= '0;
      c_q     <= 1'b0;
      cnt_q   <= '0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      sa_q    <= sa_d;
      sb_q    <= sb_d;
      sr_q    <= sr_d;
      c_q     <= c_d;
      cnt_q   <= cnt_d;
      sum_q   <= sum_d;
      cout_q  <= cout_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign busy = busy_q;
  assign done = done_q;
  assign sum  = sum_q;
  assign cout = cout_q;

endmodule

// File: tb/tb_serial_adder.sv
// tb_serial_adder: randomized self-checking
// bench for serial_adder against a + b + cin.
module tb_serial_adder;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         start = 1'b0;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic         cin = 1'b0;
  logic         busy;
  logic         done;
  logic [W-1:0] sum;
  logic         cout;

  int errors = 0;
  int checks = 0;

  serial_adder #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .a     (a),
    .b     (b),
    .cin   (cin),
    .busy  (busy),
    .done  (done),
    .sum   (sum),
    .cout  (cout)
  );

  initial forever #5 clk = ~clk;

  function automatic logic [W:0] model(
    input logic [W-1:0] x,
    input logic [W-1:0] y,
    input logic         c
  );
    int unsigned t;
    t = int'(x) + int'(y) + int'(c);
    return (W+1)'(t);
  endfunction

  // Issue one addition from IDLE and wait (bounded) for done.
  task automatic do_op(
    input  logic [W-1:0] xa,
    input  logic [W-1:0] xb,
    input  logic         xc,
    output logic [W-1:0] rs,
    output logic         rc,
    output int           lat,
    output int           bz,
    output bit           stable,
    output bit           back_idle
  );
    logic [W-1:0] ps;
    logic         pc;
    ps = sum;
    pc = cout;
    stable = 1'b1;
    @(negedge clk);
    a = xa; b = xb; cin = xc; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    a = W'($urandom); b = W'($urandom);
    cin = 1'($urandom);
    lat = 0; bz = 0;
    while (!done && lat < 40) begin
      if (busy) bz++;
      if (sum !== ps || cout !== pc) stable = 1'b0;
      @(posedge clk); #1;
      lat++;
    end
    rs = sum;
    rc = cout;
    @(posedge clk); #1;
    back_idle = !done && !busy;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    #12;
    checks++;
    if ({busy, done, cout, sum} !== '0) begin
      errors++;
      $display("FAIL reset_outputs got busy=%b done=%b cout=%b sum=%h want all 0",
               busy, done, cout, sum);
    end
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_vec(
    input string        nm,
    input logic [W-1:0] xa,
    input logic [W-1:0] xb,
    input logic         xc
  );
    logic [W-1:0] rs;
    logic         rc;
    logic [W:0]   exp;
    int           lat, bz;
    bit           st, bi;
    exp = model(xa, xb, xc);
    do_op(xa, xb, xc, rs, rc, lat, bz, st, bi);
    checks++;
    if ({rc, rs} !== exp) begin
      errors++;
      $display("FAIL %s_result got %b_%h want %b_%h",
               nm, rc, rs, exp[W], exp[W-1:0]);
    end
    checks++;
    if (lat != W || bz != W) begin
      errors++;
      $display("FAIL %s_timing got lat=%0d busy=%0d want %0d/%0d",
               nm, lat, bz, W, W);
    end
    checks++;
    if (!st || !bi) begin
      errors++;
      $display("FAIL %s_hold got stable=%0b idle=%0b want 1/1",
               nm, st, bi);
    end
  endtask

  task automatic test_basic;
    test_vec("basic", 8'h5A, 8'h33, 1'b0);
    test_vec("ripple", 8'hFF, 8'h01, 1'b0);
  endtask

  task automatic test_carry_clear;
    test_vec("allones", 8'hFF, 8'hFF, 1'b1);
    test_vec("zeros", 8'h00, 8'h00, 1'b0);
  endtask

  task automatic test_ignore_start;
    int n;
    @(negedge clk);
    a = 8'h12; b = 8'h34; cin = 1'b0; start = 1'b1;
    @(posedge clk); #1;
    a = 8'hAA; b = 8'hAA;
    n = 0;
    while (!done && n < 40) begin
      @(posedge clk); #1;
      n++;
    end
    checks++;
    if (n != W || {cout, sum} !== 9'h046) begin
      errors++;
      $display("FAIL ignore_result got lat=%0d %b_%h want %0d 0_46",
               n, cout, sum, W);
    end
    // start still high across the DONE edge: must be ignored.
    @(posedge clk); #1;
    checks++;
    if (busy !== 1'b0 || done !== 1'b0) begin
      errors++;
      $display("FAIL ignore_done got busy=%b done=%b want 0/0",
               busy, done);
    end
    // Now in IDLE: the held start is accepted here.
    @(posedge clk); #1;
    start = 1'b0;
    checks++;
    if (busy !== 1'b1) begin
      errors++;
      $display("FAIL after_done_accept got busy=%b want 1", busy);
    end
    n = 0;
    while (!done && n < 40) begin
      @(posedge clk); #1;
      n++;
    end
    checks++;
    if ({cout, sum} !== 9'h154) begin
      errors++;
      $display("FAIL after_done_result got %b_%h want 1_54", cout, sum);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_reset_mid_run;
    logic [W-1:0] rs;
    logic         rc;
    int           lat, bz, seen;
    bit           st, bi;
    @(negedge clk);
    a = 8'h7F; b = 8'h01; cin = 1'b1; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (3) @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    checks++;
    if ({busy, done, cout, sum} !== '0) begin
      errors++;
      $display("FAIL midrun_reset got busy=%b done=%b cout=%b sum=%h want 0",
               busy, done, cout, sum);
    end
    @(negedge clk);
    rst = 1'b0;
    seen = 0;
    repeat (W + 3) begin
      @(posedge clk); #1;
      if (done || busy) seen++;
    end
    checks++;
    if (seen != 0) begin
      errors++;
      $display("FAIL midrun_no_done got %0d active cycles want 0", seen);
    end
    do_op(8'h80, 8'h80, 1'b0, rs, rc, lat, bz, st, bi);
    checks++;
    if ({rc, rs} !== 9'h100 || lat != W) begin
      errors++;
      $display("FAIL post_reset_op got %b_%h lat=%0d want 1_00 %0d",
               rc, rs, lat, W);
    end
  endtask

  task automatic test_random;
    logic [W-1:0] xa, xb, rs;
    logic         xc, rc;
    logic [W:0]   exp;
    int           lat, bz;
    bit           st, bi;
    for (int i = 0; i < 1000; i++) begin
      xa = W'($urandom);
      xb = W'($urandom);
      xc = 1'($urandom);
      exp = model(xa, xb, xc);
      do_op(xa, xb, xc, rs, rc, lat, bz, st, bi);
      checks++;
      if ({rc, rs} !== exp || lat != W || !st || !bi) begin
        errors++;
        $display("FAIL rand_%0d got %b_%h lat=%0d st=%0b idle=%0b want %b_%h lat=%0d",
                 i, rc, rs, lat, st, bi, exp[W], exp[W-1:0], W);
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_carry_clear();
    test_ignore_start();
    test_reset_mid_run();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
